sign_extend: RTL and testbench
==============================

# sign_extend

Parameterized sign-extension block that widens a narrow two's-complement value to a full datapath word by replicating its most-significant bit. The data memory's load path uses it to produce signed halfword (LH) and signed byte (LB) results: one instance extends by 16 bits (16-bit in), another by 24 bits (8-bit in), both to 32 bits. The block also has an optional registered copy of the result for pipelined users. The combinational output is the primary function.

## Interface
- EXT, default 16: number of sign bits prepended; legal range 0..OUT_W-1.
- OUT_W, default 32: output width.
- IN_W (local, derived): OUT_W-EXT; never set directly.

- clk  input  1  clock for the registered output only.
- rst  input  1  reset rst, asynchronous, active-high; clears out_q only.
- en  input  1  load enable for out_q.
- in  input  IN_W  value to extend; in[IN_W-1] is the sign bit.
- out  output  OUT_W  combinational result.
- out_q  output  OUT_W  registered result.
- sign  output  1  combinational copy of in[IN_W-1].

## Operation
- out = {EXT copies of in[IN_W-1], in}.
- Bits out[IN_W-1:0] equal in exactly.
- Bits out[OUT_W-1:IN_W] all equal in[IN_W-1].
- EXT=0: out = in (pass-through); sign still equals in[OUT_W-1].
- out and sign are purely combinational functions of in.
  - They do not depend on clk, rst or en.
  - If clk/rst/en are left unconnected (as in the memory's load path), out must still be correct.
- Sign extension only; no zero-extend mode. Callers build unsigned loads by zero-concatenation outside this block.
- X/Z on in propagates to out; no masking.
- Elaboration must fail with a clear error when EXT >= OUT_W or EXT < 0.

## Timing
- out, sign: zero-cycle latency; settle within the same delta as in.
  - Must be safe inside a caller's always @(*) evaluation.
- out_q: captures out on the rising edge of clk when en=1; holds when en=0.
  - Latency is 1 cycle from in to out_q.
- Reset: rst=1 forces out_q to 0 immediately, without waiting for a clock edge.
  - out_q holds 0 while rst=1, even if en=1 and clk toggles.
  - First capture is on the first rising edge after rst deasserts with en=1.
- Reset has no effect on out or sign at any time, including mid-operation.
- Simultaneous rst rising and a clk edge with en=1: reset wins; out_q=0.
- No handshake and no state machine beyond the single out_q register.

## Test plan
- EXT=16, OUT_W=32:
  - in=16'h8001 -> out=32'hFFFF_8001, sign=1.
  - in=16'h7FFF -> out=32'h0000_7FFF, sign=0.
- EXT=24, OUT_W=32:
  - in=8'h80 -> out=32'hFFFF_FF80.
  - in=8'h7F -> out=32'h0000_007F.
  - in=8'hFF -> out=32'hFFFF_FFFF.
  - in=8'h00 -> out=32'h0000_0000.
- Combinational independence (EXT=16): clk, rst, en held at Z/0.
  - Sweep in over 16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF.
  - Required out: 32'h0000_0000, 32'h0000_7FFF, 32'hFFFF_8000, 32'hFFFF_FFFF, each with no clock applied.
- Registered path (EXT=24): rst pulse, then en=1, in=8'h9C.
  - out_q=0 before the edge; 32'hFFFF_FF9C after the first rising clk edge.
  - Then en=0, in=8'h01: out_q holds FFFF_FF9C while out=32'h0000_0001.
- Async reset mid-operation: with out_q=32'hFFFF_FF9C, assert rst between clock edges.
  - out_q goes to 0 before the next edge; out is unchanged.
- EXT=0, OUT_W=32: in=32'h8000_0000 -> out=32'h8000_0000, sign=1.
- Elaborating EXT=32, OUT_W=32 must be rejected.

Source files
------------

// File: rtl/sign_extend.sv
// Two's-complement sign extension from IN_W to OUT_W bits, with an
// optional registered copy of the result for pipelined users.
module sign_extend #(
    parameter int EXT   = 16,
    parameter int OUT_W = 32,
    localparam int IN_W = OUT_W - EXT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic [OUT_W-1:0] out_q,
    output logic             sign
);

    if (EXT < 0 || EXT >= OUT_W) begin : g_bad_ext
        $error("sign_extend: EXT=%0d illegal, must be in 0..OUT_W-1 (OUT_W=%0d)",
               EXT, OUT_W);
    end

    assign sign = in[IN_W-1];

    // Continuous assigns keep out/sign free of clk, rst and en, and let
    // X/Z on in reach out unmasked.
    if (EXT == 0) begin : g_pass
        assign out = in;
    end else begin : g_ext
        assign out = {{EXT{in[IN_W-1]}}, in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else if (en) begin
            out_q <= out;
        end
    end

endmodule

// File: tb/tb_sign_extend.sv
// Scoreboard bench for sign_extend: stimulus queues expected values,
// a monitor process pops and compares them against the DUT outputs.
module tb_sign_extend;

    typedef struct {
        int          id;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    event chk;
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    always #5 clk = ~clk;

    // EXT=16
    logic [15:0] in16 = '0;
    logic [31:0] out16, outq16;
    logic        sign16;
    sign_extend #(.EXT(16), .OUT_W(32)) u16 (
        .clk(clk), .rst(rst), .en(en), .in(in16),
        .out(out16), .out_q(outq16), .sign(sign16)
    );

    // EXT=24, also exercises the register
    logic [7:0]  in24 = '0;
    logic [31:0] out24, outq24;
    logic        sign24;
    sign_extend #(.EXT(24), .OUT_W(32)) u24 (
        .clk(clk), .rst(rst), .en(en), .in(in24),
        .out(out24), .out_q(outq24), .sign(sign24)
    );

    // EXT=16 with clk/rst/en tied off
    logic        tie_clk = 1'b0;
    logic        tie_rst = 1'b0;
    logic        tie_en  = 1'b0;
    logic [15:0] inz = '0;
    logic [31:0] outz, outqz;
    logic        signz;
    sign_extend #(.EXT(16), .OUT_W(32)) uz (
        .clk(tie_clk), .rst(tie_rst), .en(tie_en), .in(inz),
        .out(outz), .out_q(outqz), .sign(signz)
    );

    // EXT=0 pass-through
    logic [31:0] in0 = '0;
    logic [31:0] out0, outq0;
    logic        sign0;
    sign_extend #(.EXT(0), .OUT_W(32)) u0 (
        .clk(clk), .rst(rst), .en(en), .in(in0),
        .out(out0), .out_q(outq0), .sign(sign0)
    );

    function automatic logic [31:0] actual(int id);
        case (id)
            0:       return out16;
            1:       return {31'd0, sign16};
            2:       return out24;
            3:       return outq24;
            4:       return outz;
            5:       return out0;
            6:       return {31'd0, sign0};
            7:       return {31'd0, sign24};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor
    initial begin
        forever begin
            @(chk);
            #1;
            while (exp_q.size() > 0) begin
                exp_t e;
                logic [31:0] a;
                e = exp_q.pop_front();
                a = actual(e.id);
                n_cmp++;
                if (a !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
                end
            end
        end
    end

    task automatic expect_val(input int id, input logic [31:0] v,
                              input string name);
        exp_t e;
        e.id   = id;
        e.exp  = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic fire();
        int waited;
        ->chk;
        waited = 0;
        while (exp_q.size() > 0 && waited < 50) begin
            #1;
            waited++;
        end
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL monitor_timeout: %0d pending, expected 0",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        // Reset state of the register
        @(negedge clk);
        rst = 1'b1;
        #1;
        expect_val(3, 32'h0, "reset_out_q");
        fire();
        @(negedge clk);
        rst = 1'b0;

        // EXT=16
        in16 = 16'h8001;
        expect_val(0, 32'hFFFF_8001, "e16_8001_out");
        expect_val(1, 32'h1, "e16_8001_sign");
        fire();
        in16 = 16'h7FFF;
        expect_val(0, 32'h0000_7FFF, "e16_7fff_out");
        expect_val(1, 32'h0, "e16_7fff_sign");
        fire();

        // EXT=24
        in24 = 8'h80;
        expect_val(2, 32'hFFFF_FF80, "e24_80");
        expect_val(7, 32'h1, "e24_80_sign");
        fire();
        in24 = 8'h7F;
        expect_val(2, 32'h0000_007F, "e24_7f");
        fire();
        in24 = 8'hFF;
        expect_val(2, 32'hFFFF_FFFF, "e24_ff");
        fire();
        in24 = 8'h00;
        expect_val(2, 32'h0000_0000, "e24_00");
        expect_val(7, 32'h0, "e24_00_sign");
        fire();

        // Tied-off instance, no clock ever applied
        inz = 16'h0000;
        expect_val(4, 32'h0000_0000, "tie_0000");
        fire();
        inz = 16'h7FFF;
        expect_val(4, 32'h0000_7FFF, "tie_7fff");
        fire();
        inz = 16'h8000;
        expect_val(4, 32'hFFFF_8000, "tie_8000");
        fire();
        inz = 16'hFFFF;
        expect_val(4, 32'hFFFF_FFFF, "tie_ffff");
        fire();

        // EXT=0
        in0 = 32'h8000_0000;
        expect_val(5, 32'h8000_0000, "e0_out");
        expect_val(6, 32'h1, "e0_sign");
        fire();
        in0 = 32'h7FFF_FFFF;
        expect_val(5, 32'h7FFF_FFFF, "e0_out_pos");
        expect_val(6, 32'h0, "e0_sign_pos");
        fire();

        // Registered path: rst pulse, hold through an edge with en=1
        @(negedge clk);
        rst  = 1'b1;
        en   = 1'b1;
        in24 = 8'h9C;
        @(posedge clk);
        #1;
        expect_val(3, 32'h0, "rst_blocks_capture");
        fire();
        @(negedge clk);
        rst = 1'b0;
        #1;
        expect_val(3, 32'h0, "before_first_edge");
        expect_val(2, 32'hFFFF_FF9C, "out_9c");
        fire();
        @(posedge clk);
        #1;
        expect_val(3, 32'hFFFF_FF9C, "first_capture");
        fire();

        // Hold with en=0
        @(negedge clk);
        en   = 1'b0;
        in24 = 8'h01;
        @(posedge clk);
        #1;
        expect_val(3, 32'hFFFF_FF9C, "hold_en0");
        expect_val(2, 32'h0000_0001, "out_01");
        fire();

        // Async reset between edges
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        expect_val(3, 32'h0, "async_rst_out_q");
        expect_val(2, 32'h0000_0001, "async_rst_out");
        fire();
        rst = 1'b0;

        #20;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
